activate: RTL and testbench
===========================

Name: activate

Overview:
- Activation stage directly downstream of `associate`. Forward pass: takes the 16-bit signed weighted sum on `arg` and returns an 8-bit unsigned activation on `res`, which feeds the next `associate` argument lane.
- Backward pass: when training, takes the error from the downstream stage, gates it by the stored activation derivative, and returns it upstream on `fbk` as `associate`'s `err`.
- Forward and backward use independent stb/rdy handshakes and are sequenced by a small FSM.

Parameters:
- ARGW, 16, width of signed forward input (matches associate RESW).
- RESW, 8, width of unsigned activation output.
- ERRW, 16, width of signed backward error input.
- FBKW, 16, width of signed feedback output (equals ERRW).
- FUNC, 0, activation select: 0 = step (threshold), 1 = saturating ReLU.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  training enable; sampled at forward acceptance.
- arg_stb  input  1  forward input valid.
- arg_dat  input  ARGW  signed weighted sum.
- arg_rdy  output  1  forward input ready.
- res_stb  output  1  activation valid.
- res_dat  output  RESW  activation value.
- res_rdy  input  1  activation accepted downstream.
- err_stb  input  1  backward error valid.
- err_dat  input  ERRW  signed error.
- err_rdy  output  1  error ready.
- fbk_stb  output  1  feedback valid.
- fbk_dat  output  FBKW  signed gated error to upstream.
- fbk_rdy  input  1  feedback accepted upstream.

Behaviour:
- Transfer rule: a transfer occurs on a rising `clk` when stb & rdy are both high. A stb, once asserted, holds with stable data until accepted.
- States:
  - IDLE: `arg_rdy`=1.
  - FWD: `res_stb`=1.
  - BWD: `err_rdy`=1.
  - FBK: `fbk_stb`=1.
  - Every other handshake output is 0 in each state.
- Transitions:
  - IDLE→FWD on arg transfer. The same edge registers `res_dat`, the derivative bit `drv`, and `trn`=en.
  - FWD→BWD on res transfer if `trn`=1; FWD→IDLE on res transfer if `trn`=0.
  - BWD→FBK on err transfer. The same edge registers `fbk_dat` = `drv` ? `err_dat` : 0.
  - FBK→IDLE on fbk transfer.
- Latency: `res_stb` rises 1 cycle after arg acceptance; `fbk_stb` rises 1 cycle after err acceptance. Maximum throughput is one forward per 2 cycles with en=0.
- FUNC=0 (step):
  - `res_dat` = ($signed(arg) < 0) ? 0 : 2**RESW-1.
  - `drv` = 1 always (perceptron rule: error passes through).
- FUNC=1 (ReLU, saturating):
  - arg<0 → res 0, drv 0.
  - arg>2**RESW-1 → res 2**RESW-1, drv 0.
  - Otherwise res = arg[RESW-1:0], drv 1.
  - Boundaries: arg=0 → res 0, drv 1; arg=255 → res 255, drv 1; arg=256 → res 255, drv 0; arg=-1 → res 0, drv 0.
- en changes after forward acceptance have no effect on the current sample; `trn` is latched.
- `err_stb` asserted outside BWD is ignored (`err_rdy`=0). `arg_stb` outside IDLE is stalled (`arg_rdy`=0).
- Reset values: state IDLE, `arg_rdy`=1 from the first cycle after reset, all stb outputs 0, `res_dat`=0, `fbk_dat`=0, `drv`=0, `trn`=0.
- Reset asserted in any state aborts the pending transaction with no output transfer on that edge.
- No internal buffering beyond one sample; backpressure on `res_rdy`/`fbk_rdy` holds the FSM indefinitely with outputs stable.

Decomposition:
- Shared package `machina_pkg` holds:
  - the FUNC encodings as a typedef enum `act_func_t` (STEP=0, RELU=1);
  - the FSM state typedef `act_state_t`;
  - width constants shared with `associate` (ARGW/RESW/ERRW), so the two stages agree by construction.
- One combinational sub-module, `activate_fn` (arg → res, drv; parameterised by FUNC), keeps the function swappable and unit-testable. The top holds the FSM and registers.

Test Plan:
- Reset then FUNC=0, en=0, arg=16'hfff0: `res_stb` one cycle after accept, `res_dat`=8'h00; FSM back to IDLE; `err_rdy` never asserts.
- FUNC=0, en=1, arg=16'h0005 → `res_dat`=8'hff; then err=16'hff01 → `fbk_dat`=16'hff01 one cycle after err accept.
- FUNC=1, en=1, arg sweep {-1, 0, 255, 256} with err=16'h0010 each: res {0, 0, 255, 255}; fbk {0, 16'h0010, 16'h0010, 0}.
- Backpressure: hold `res_rdy`=0 for 5 cycles after arg accept: `res_stb`=1 and `res_dat` stable throughout, `arg_rdy`=0. Same check on `fbk_rdy`.
- Reset mid-BWD (after res accepted, before err): next cycle all stb=0 and `arg_rdy`=1; a following en=0 forward completes normally.
- Loop with `associate`: 25 epochs of AND then OR training as in the associate bench, using this block in place of the bench threshold. Final en=0 pass yields zero error for all four inputs.

Source files
------------

// File: rtl/machina_pkg.sv
// Shared types and widths for the associate/activate neuron pipeline.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package machina_pkg;

    localparam int ARGW = 16;
    localparam int RESW = 8;
    localparam int ERRW = 16;

    typedef enum logic {
        STEP = 1'b0,
        RELU = 1'b1
    } act_func_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        BWD  = 2'd2,
        FBK  = 2'd3
    } act_state_t;

endpackage

// File: rtl/activate_fn.sv
// Activation function: signed weighted sum -> unsigned activation plus derivative bit.
// Latency: combinational.
// Backpressure: none (pure function).
module activate_fn
    import machina_pkg::*;
#(
    parameter act_func_t FUNC = STEP,
    parameter int        AW   = ARGW,
    parameter int        RW   = RESW
) (
    input  logic [AW-1:0] arg,
    output logic [RW-1:0] res,
    output logic          drv
);

    localparam logic [AW-1:0] RMAX = {{(AW-RW){1'b0}}, {RW{1'b1}}};

    always_comb begin
        res = '0;
        drv = 1'b0;
        if (FUNC == STEP) begin
            // Perceptron rule: the error always passes back unchanged.
            res = arg[AW-1] ? '0 : '1;
            drv = 1'b1;
        end else begin
            if (arg[AW-1]) begin
                res = '0;
                drv = 1'b0;
            end else if (arg > RMAX) begin
                res = '1;
                drv = 1'b0;
            end else begin
                res = arg[RW-1:0];
                drv = 1'b1;
            end
        end
    end

endmodule

// File: rtl/activate.sv
// Activation stage: forward activation of associate's sum, backward derivative-gated error.
// Latency: res_stb 1 cycle after arg accept; fbk_stb 1 cycle after err accept.
// Backpressure: single-sample; res_rdy/fbk_rdy low holds the FSM with outputs stable.
module activate
    import machina_pkg::*;
#(
    parameter int        ARGW = machina_pkg::ARGW,
    parameter int        RESW = machina_pkg::RESW,
    parameter int        ERRW = machina_pkg::ERRW,
    parameter int        FBKW = ERRW,
    parameter act_func_t FUNC = STEP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            arg_stb,
    input  logic [ARGW-1:0] arg_dat,
    output logic            arg_rdy,
    output logic            res_stb,
    output logic [RESW-1:0] res_dat,
    input  logic            res_rdy,
    input  logic            err_stb,
    input  logic [ERRW-1:0] err_dat,
    output logic            err_rdy,
    output logic            fbk_stb,
    output logic [FBKW-1:0] fbk_dat,
    input  logic            fbk_rdy
);

    act_state_t      state;
    logic            drv;
    logic            trn;
    logic [RESW-1:0] fn_res;
    logic            fn_drv;

    activate_fn #(
        .FUNC (FUNC),
        .AW   (ARGW),
        .RW   (RESW)
    ) u_fn (
        .arg (arg_dat),
        .res (fn_res),
        .drv (fn_drv)
    );

    // Handshake outputs are registered alongside the state so each is a pure state decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            arg_rdy <= 1'b1;
            res_stb <= 1'b0;
            err_rdy <= 1'b0;
            fbk_stb <= 1'b0;
            res_dat <= '0;
            fbk_dat <= '0;
            drv     <= 1'b0;
            trn     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (arg_stb) begin
                    state   <= FWD;
                    arg_rdy <= 1'b0;
                    res_stb <= 1'b1;
                    res_dat <= fn_res;
                    drv     <= fn_drv;
                    trn     <= en;
                end
                FWD: if (res_rdy) begin
                    res_stb <= 1'b0;
                    if (trn) begin
                        state   <= BWD;
                        err_rdy <= 1'b1;
                    end else begin
                        state   <= IDLE;
                        arg_rdy <= 1'b1;
                    end
                end
                BWD: if (err_stb) begin
                    state   <= FBK;
                    err_rdy <= 1'b0;
                    fbk_stb <= 1'b1;
                    fbk_dat <= drv ? FBKW'(err_dat) : '0;
                end
                FBK: if (fbk_rdy) begin
                    state   <= IDLE;
                    fbk_stb <= 1'b0;
                    arg_rdy <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    arg_rdy <= 1'b1;
                    res_stb <= 1'b0;
                    err_rdy <= 1'b0;
                    fbk_stb <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_activate.sv
// Directed bench: step and ReLU instances share stimulus, scoreboards hold expected res/fbk.
module tb_activate;
    import machina_pkg::*;

    logic        clk = 1'b0;
    logic        rst, en, arg_stb, res_rdy, err_stb, fbk_rdy;
    logic [15:0] arg_dat, err_dat;

    logic        s_arg_rdy, s_res_stb, s_err_rdy, s_fbk_stb;
    logic [7:0]  s_res_dat;
    logic [15:0] s_fbk_dat;
    logic        r_arg_rdy, r_res_stb, r_err_rdy, r_fbk_stb;
    logic [7:0]  r_res_dat;
    logic [15:0] r_fbk_dat;

    int n_run  = 0;
    int n_fail = 0;

    logic [15:0] exp_res_q[$];   // {step, relu}
    logic [31:0] exp_fbk_q[$];   // {step, relu}

    always #5 clk = ~clk;

    activate #(.FUNC(STEP)) u_step (
        .clk(clk), .rst(rst), .en(en),
        .arg_stb(arg_stb), .arg_dat(arg_dat), .arg_rdy(s_arg_rdy),
        .res_stb(s_res_stb), .res_dat(s_res_dat), .res_rdy(res_rdy),
        .err_stb(err_stb), .err_dat(err_dat), .err_rdy(s_err_rdy),
        .fbk_stb(s_fbk_stb), .fbk_dat(s_fbk_dat), .fbk_rdy(fbk_rdy)
    );

    activate #(.FUNC(RELU)) u_relu (
        .clk(clk), .rst(rst), .en(en),
        .arg_stb(arg_stb), .arg_dat(arg_dat), .arg_rdy(r_arg_rdy),
        .res_stb(r_res_stb), .res_dat(r_res_dat), .res_rdy(res_rdy),
        .err_stb(err_stb), .err_dat(err_dat), .err_rdy(r_err_rdy),
        .fbk_stb(r_fbk_stb), .fbk_dat(r_fbk_dat), .fbk_rdy(fbk_rdy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_arg_rdy"}, {s_arg_rdy, r_arg_rdy}, 2'b11);
        chk({tag, "_stbs"}, {s_res_stb, r_res_stb, s_err_rdy, r_err_rdy, s_fbk_stb, r_fbk_stb}, 6'b0);
    endtask

    task automatic send_arg(input logic [15:0] a, input logic e, input logic [7:0] es, input logic [7:0] er);
        bit ok = 1'b0;
        arg_dat = a;
        en      = e;
        arg_stb = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ok = s_arg_rdy;
            cyc();
            if (ok) break;
        end
        chk("arg_accept", 32'(ok), 32'd1);
        arg_stb = 1'b0;
        arg_dat = 16'hdead;
        en      = ~e;   // trn must already be latched
        exp_res_q.push_back({es, er});
        chk("res_stb_latency", {s_res_stb, r_res_stb, s_arg_rdy, r_arg_rdy}, 4'b1100);
    endtask

    task automatic take_res();
        bit          ok = 1'b0;
        logic [15:0] e;
        res_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (s_res_stb) begin
                ok = 1'b1;
                chk("res_q_nonempty", 32'(exp_res_q.size() > 0), 32'd1);
                if (exp_res_q.size() > 0) begin
                    e = exp_res_q.pop_front();
                    chk("res_dat_step", 32'(s_res_dat), 32'(e[15:8]));
                    chk("res_dat_relu", 32'(r_res_dat), 32'(e[7:0]));
                end
            end
            cyc();
            if (ok) break;
        end
        res_rdy = 1'b0;
        chk("res_seen", 32'(ok), 32'd1);
    endtask

    task automatic send_err(input logic [15:0] d, input logic [15:0] fs, input logic [15:0] fr);
        bit ok = 1'b0;
        err_dat = d;
        err_stb = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ok = s_err_rdy;
            cyc();
            if (ok) break;
        end
        chk("err_accept", 32'(ok), 32'd1);
        err_stb = 1'b0;
        err_dat = 16'hbeef;
        exp_fbk_q.push_back({fs, fr});
        chk("fbk_stb_latency", {s_fbk_stb, r_fbk_stb, s_err_rdy, r_err_rdy}, 4'b1100);
    endtask

    task automatic take_fbk();
        bit          ok = 1'b0;
        logic [31:0] e;
        fbk_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (s_fbk_stb) begin
                ok = 1'b1;
                chk("fbk_q_nonempty", 32'(exp_fbk_q.size() > 0), 32'd1);
                if (exp_fbk_q.size() > 0) begin
                    e = exp_fbk_q.pop_front();
                    chk("fbk_dat_step", 32'(s_fbk_dat), 32'(e[31:16]));
                    chk("fbk_dat_relu", 32'(r_fbk_dat), 32'(e[15:0]));
                end
            end
            cyc();
            if (ok) break;
        end
        fbk_rdy = 1'b0;
        chk("fbk_seen", 32'(ok), 32'd1);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; arg_stb = 1'b0; arg_dat = '0;
        res_rdy = 1'b0; err_stb = 1'b0; err_dat = '0; fbk_rdy = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        cyc();

        // Reset state
        chk_idle("reset");
        chk("reset_res_dat", {s_res_dat, r_res_dat}, 16'h0);
        chk("reset_fbk_dat", {s_fbk_dat, r_fbk_dat}, 32'h0);

        // Negative arg, en=0; a stray err_stb must never be taken
        err_stb = 1'b1;
        err_dat = 16'h7777;
        send_arg(16'hfff0, 1'b0, 8'h00, 8'h00);
        take_res();
        for (int i = 0; i < 3; i++) begin
            chk_idle("en0_back_idle");
            cyc();
        end
        err_stb = 1'b0;

        // Positive arg, en=1, error passes through derivative
        send_arg(16'h0005, 1'b1, 8'hff, 8'h05);
        take_res();
        send_err(16'hff01, 16'hff01, 16'hff01);
        take_fbk();
        chk_idle("fbk_done");

        // ReLU boundary sweep with err=0x0010
        send_arg(16'hffff, 1'b1, 8'h00, 8'h00); take_res();
        send_err(16'h0010, 16'h0010, 16'h0000); take_fbk();
        send_arg(16'h0000, 1'b1, 8'hff, 8'h00); take_res();
        send_err(16'h0010, 16'h0010, 16'h0010); take_fbk();
        send_arg(16'h00ff, 1'b1, 8'hff, 8'hff); take_res();
        send_err(16'h0010, 16'h0010, 16'h0010); take_fbk();
        send_arg(16'h0100, 1'b1, 8'hff, 8'hff); take_res();
        send_err(16'h0010, 16'h0010, 16'h0000); take_fbk();

        // Backpressure on res and fbk; a competing arg must stall
        send_arg(16'h0080, 1'b1, 8'hff, 8'h80);
        arg_stb = 1'b1;
        arg_dat = 16'h8000;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_res_stb", {s_res_stb, r_res_stb, s_arg_rdy, r_arg_rdy}, 4'b1100);
            chk("bp_res_dat", {s_res_dat, r_res_dat}, 16'hff80);
        end
        arg_stb = 1'b0;
        take_res();
        send_err(16'h1234, 16'h1234, 16'h1234);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_fbk_stb", {s_fbk_stb, r_fbk_stb, s_err_rdy, r_err_rdy, s_arg_rdy}, 5'b11000);
            chk("bp_fbk_dat", {s_fbk_dat, r_fbk_dat}, 32'h12341234);
        end
        take_fbk();

        // Reset while waiting in BWD
        send_arg(16'h0010, 1'b1, 8'hff, 8'h10);
        take_res();
        chk("bwd_err_rdy", {s_err_rdy, r_err_rdy}, 2'b11);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk_idle("mid_bwd_reset");
        send_arg(16'h0064, 1'b0, 8'hff, 8'h64);
        take_res();
        chk_idle("after_reset_fwd");

        chk("res_q_drained", 32'(exp_res_q.size()), 32'd0);
        chk("fbk_q_drained", 32'(exp_fbk_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
